// File: rtl/cache_4way.sv
// cache_4way: 4-way set-associative, write-allocate, cache-only-write cache
// controller. Lines of 2**WORD_OFFSET words, 2**INDEX_WIDTH sets. A miss
// refills the victim line one word at a time from memory, then answers the CPU.
// Optional build macro CACHE_LRU_EN selects true LRU replacement (2-bit age
// per way); without it a per-set round-robin pointer advanced on refill is used.
module cache_4way #(
  parameter int ADR_WIDTH   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WORD_OFFSET = 2,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_cpu2cc,
  input  logic [ADR_WIDTH-1:0]   adr_cpu2cc,
  input  logic [DATA_WIDTH-1:0]  dat_cpu2cc,
  input  logic                   rdwr_cpu2cc,
  output logic                   ack_cc2cpu,
  output logic [DATA_WIDTH-1:0]  dat_cc2cpu,
  output logic                   req_cc2mem,
  output logic [ADR_WIDTH-1:0]   adr_cc2mem,
  input  logic                   ack_mem2cc,
  input  logic [DATA_WIDTH-1:0]  dat_mem2cc,
  output logic [DATA_WIDTH-1:0]  dat_mem2mshr,
  output logic [WORD_OFFSET-1:0] word_mem2mshr,
  output logic [DATA_WIDTH-1:0]  dat_cc2mshr
);

  localparam int WAYS      = 32'sd4;
  localparam int SETS      = 32'sd1 << INDEX_WIDTH;
  localparam int WORDS     = 32'sd1 << WORD_OFFSET;
  localparam int WLSB      = 32'sd2;
  localparam int ILSB      = WLSB + WORD_OFFSET;
  localparam int TLSB      = ILSB + INDEX_WIDTH;
  localparam int TAG_WIDTH = ADR_WIDTH - TLSB;

  localparam logic [WORD_OFFSET-1:0] WORD_LAST = '1;
  localparam logic [WORD_OFFSET-1:0] WORD_INC  = WORD_OFFSET'(1'b1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    REFILL = 3'd2,
    RESP   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Lowest-numbered set bit of a 4-bit way vector.
  function automatic logic [1:0] first_set(input logic [3:0] vec);
    logic [1:0] way;
    casez (vec)
      4'b???1: way = 2'd0;
      4'b??10: way = 2'd1;
      4'b?100: way = 2'd2;
      4'b1000: way = 2'd3;
      default: way = 2'd0;
    endcase
    return way;
  endfunction

  // Storage
  logic [DATA_WIDTH-1:0] data_r [SETS][WAYS][WORDS];
  logic [TAG_WIDTH-1:0]  tag_r  [SETS][WAYS];
  logic [3:0]            valid_r [SETS];
`ifdef CACHE_LRU_EN
  logic [1:0]            age_r [SETS][WAYS];
`else
  logic [1:0]            ptr_r [SETS];
`endif

  // Request / FSM registers
  state_t                 state_r;
  logic [ADR_WIDTH-1:2]   adr_r;
  logic [DATA_WIDTH-1:0]  wdata_r;
  logic                   rdwr_r;
  logic [1:0]             way_r;
  logic [WORD_OFFSET-1:0] word_cnt_r;
  logic                   ack_r;
  logic [DATA_WIDTH-1:0]  rdata_r;
  logic                   mem_req_r;
  logic [ADR_WIDTH-1:0]   mem_adr_r;
  logic [DATA_WIDTH-1:0]  mem_dat_r;

  // Combinational helpers
  logic [1:0]             byte_unused_s;
  logic [TAG_WIDTH-1:0]   tag_s;
  logic [INDEX_WIDTH-1:0] idx_s;
  logic [WORD_OFFSET-1:0] word_s;
  logic [3:0]             hit_vec_s;
  logic                   hit_s;
  logic [1:0]             hit_way_s;
  logic [1:0]             policy_way_s;
  logic [1:0]             victim_s;
  logic                   hit_upd_s;
  logic                   miss_s;
  logic                   last_ack_s;
  logic [DATA_WIDTH-1:0]  line_word_s;
  logic [DATA_WIDTH-1:0]  fill_word_s;
`ifdef CACHE_LRU_EN
  logic [3:0]             oldest_s;
  logic [1:0]             acc_way_s;
  logic [1:0]             acc_old_s;
`endif

  // Byte offset within a word plays no role in a word-addressed cache.
  assign byte_unused_s = adr_cpu2cc[1:0];

  assign tag_s  = adr_r[ADR_WIDTH-1:TLSB];
  assign idx_s  = adr_r[TLSB-1:ILSB];
  assign word_s = adr_r[ILSB-1:WLSB];

  assign ack_cc2cpu    = ack_r;
  assign dat_cc2cpu    = rdata_r;
  assign req_cc2mem    = mem_req_r;
  assign adr_cc2mem    = mem_adr_r;
  assign dat_mem2mshr  = mem_dat_r;
  assign word_mem2mshr = word_cnt_r;
  assign dat_cc2mshr   = wdata_r;

  // Tag match of every way in the addressed set.
  always_comb begin
    hit_vec_s = 4'b0000;
    for (int w = 32'sd0; w < WAYS; w++) begin
      hit_vec_s[w] = valid_r[idx_s][w] && (tag_r[idx_s][w] == tag_s);
    end
  end

  assign hit_s     = |hit_vec_s;
  assign hit_way_s = first_set(hit_vec_s);

  // Victim choice: an empty way first, otherwise the replacement policy.
  always_comb begin
`ifdef CACHE_LRU_EN
    oldest_s = 4'b0000;
    for (int w = 32'sd0; w < WAYS; w++) begin
      oldest_s[w] = (age_r[idx_s][w] == 2'd3);
    end
    policy_way_s = first_set(oldest_s);
`else
    policy_way_s = ptr_r[idx_s];
`endif
    if (valid_r[idx_s] != 4'b1111) begin
      victim_s = first_set(~valid_r[idx_s]);
    end else begin
      victim_s = policy_way_s;
    end
  end

  assign hit_upd_s  = (state_r == LOOKUP) && hit_s;
  assign miss_s     = (state_r == LOOKUP) && !hit_s;
  assign last_ack_s = (state_r == REFILL) && ack_mem2cc && (word_cnt_r == WORD_LAST);

  // Response word for a hit, and for refill completion where the last word
  // is still on the memory bus rather than in the array.
  always_comb begin
    line_word_s = data_r[idx_s][hit_way_s][word_s];
    if (word_s == WORD_LAST) begin
      fill_word_s = dat_mem2cc;
    end else begin
      fill_word_s = data_r[idx_s][way_r][word_s];
    end
  end

`ifdef CACHE_LRU_EN
  // Way being touched and its previous age; a refilled way counts as oldest.
  always_comb begin
    if (hit_upd_s) begin
      acc_way_s = hit_way_s;
      acc_old_s = age_r[idx_s][hit_way_s];
    end else begin
      acc_way_s = way_r;
      acc_old_s = 2'd3;
    end
  end
`endif

  // Controller FSM with all CPU/memory-facing outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      adr_r      <= '0;
      wdata_r    <= '0;
      rdwr_r     <= 1'b0;
      way_r      <= 2'd0;
      word_cnt_r <= '0;
      ack_r      <= 1'b0;
      rdata_r    <= '0;
      mem_req_r  <= 1'b0;
      mem_adr_r  <= '0;
      mem_dat_r  <= '0;
    end else begin
      ack_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_cpu2cc) begin
            adr_r   <= adr_cpu2cc[ADR_WIDTH-1:2];
            wdata_r <= dat_cpu2cc;
            rdwr_r  <= rdwr_cpu2cc;
            state_r <= LOOKUP;
          end else begin
            state_r <= IDLE;
          end
        end
        LOOKUP: begin
          if (hit_s) begin
            way_r   <= hit_way_s;
            ack_r   <= 1'b1;
            rdata_r <= rdwr_r ? wdata_r : line_word_s;
            state_r <= RESP;
          end else begin
            way_r      <= victim_s;
            word_cnt_r <= '0;
            mem_req_r  <= 1'b1;
            mem_adr_r  <= {tag_s, idx_s, {WORD_OFFSET{1'b0}}, 2'b00};
            state_r    <= REFILL;
          end
        end
        REFILL: begin
          if (ack_mem2cc) begin
            mem_dat_r <= dat_mem2cc;
            if (word_cnt_r == WORD_LAST) begin
              word_cnt_r <= '0;
              mem_req_r  <= 1'b0;
              mem_adr_r  <= '0;
              ack_r      <= 1'b1;
              rdata_r    <= rdwr_r ? wdata_r : fill_word_s;
              state_r    <= RESP;
            end else begin
              word_cnt_r <= word_cnt_r + WORD_INC;
              mem_adr_r  <= {tag_s, idx_s, word_cnt_r + WORD_INC, 2'b00};
              state_r    <= REFILL;
            end
          end else begin
            state_r <= REFILL;
          end
        end
        RESP: begin
          state_r <= DONE;
        end
        DONE: begin
          if (!req_cpu2cc) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Line storage: refill words and tag during REFILL, CPU write merged in RESP.
  always_ff @(posedge clk) begin
    if ((state_r == REFILL) && ack_mem2cc) begin
      data_r[idx_s][way_r][word_cnt_r] <= dat_mem2cc;
      if (word_cnt_r == WORD_LAST) begin
        tag_r[idx_s][way_r] <= tag_s;
      end
    end else if ((state_r == RESP) && rdwr_r) begin
      data_r[idx_s][way_r][word_s] <= wdata_r;
    end
  end

  // Valid bits and replacement state; victim is invalidated while it refills.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 32'sd0; s < SETS; s++) begin
        valid_r[s] <= 4'b0000;
`ifdef CACHE_LRU_EN
        for (int w = 32'sd0; w < WAYS; w++) begin
          age_r[s][w] <= 2'd0;
        end
`else
        ptr_r[s] <= 2'd0;
`endif
      end
    end else begin
      if (miss_s) begin
        valid_r[idx_s][victim_s] <= 1'b0;
      end else if (last_ack_s) begin
        valid_r[idx_s][way_r] <= 1'b1;
      end
`ifdef CACHE_LRU_EN
      if (hit_upd_s || last_ack_s) begin
        for (int w = 32'sd0; w < WAYS; w++) begin
          if (2'(w) == acc_way_s) begin
            age_r[idx_s][w] <= 2'd0;
          end else if (age_r[idx_s][w] < acc_old_s) begin
            age_r[idx_s][w] <= age_r[idx_s][w] + 2'd1;
          end
        end
      end
`else
      if (last_ack_s) begin
        ptr_r[idx_s] <= ptr_r[idx_s] + 2'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cache_4way.sv
// Self-checking bench for cache_4way: table of CPU operations with a
// response scoreboard, a latency-varying memory model, and hand-written
// sequences for stray memory acks, held requests and reset during refill.
module tb_cache_4way;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_cpu2cc;
  logic [31:0] adr_cpu2cc;
  logic [31:0] dat_cpu2cc;
  logic        rdwr_cpu2cc;
  logic        ack_cc2cpu;
  logic [31:0] dat_cc2cpu;
  logic        req_cc2mem;
  logic [31:0] adr_cc2mem;
  logic        ack_mem2cc;
  logic [31:0] dat_mem2cc;
  logic [31:0] dat_mem2mshr;
  logic [1:0]  word_mem2mshr;
  logic [31:0] dat_cc2mshr;

  always #5 clk = ~clk;

  cache_4way #(
    .ADR_WIDTH(32), .DATA_WIDTH(32), .WORD_OFFSET(2), .INDEX_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_cpu2cc(req_cpu2cc), .adr_cpu2cc(adr_cpu2cc), .dat_cpu2cc(dat_cpu2cc),
    .rdwr_cpu2cc(rdwr_cpu2cc), .ack_cc2cpu(ack_cc2cpu), .dat_cc2cpu(dat_cc2cpu),
    .req_cc2mem(req_cc2mem), .adr_cc2mem(adr_cc2mem), .ack_mem2cc(ack_mem2cc),
    .dat_mem2cc(dat_mem2cc), .dat_mem2mshr(dat_mem2mshr),
    .word_mem2mshr(word_mem2mshr), .dat_cc2mshr(dat_cc2mshr)
  );

  typedef struct {
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] exp;
    logic        miss;
  } vec_t;

  vec_t        vecs [13];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q [$];
  logic [31:0] mem_log [$];
  int          stray_req  = 0;
  int          stray_done = 0;
  int          lat = 0;
  int          lat_sel = 0;

  // Backing memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] r;
    if (a == 32'h00CC3B40) r = 32'h754CD4A5;
    else                   r = {a[15:0], ~a[15:0]} ^ 32'h13579BDF;
    return r;
  endfunction

  // Memory: answers refill requests with a varying gap, can inject a stray ack.
  always @(negedge clk) begin
    ack_mem2cc = 1'b0;
    if (!rst) begin
      lat = 0;
    end else if (stray_req != stray_done) begin
      ack_mem2cc = 1'b1;
      dat_mem2cc = 32'hDEADBEEF;
      stray_done = stray_req;
    end else if (req_cc2mem) begin
      if (lat == 0) begin
        ack_mem2cc = 1'b1;
        dat_mem2cc = mem_word(adr_cc2mem);
        mem_log.push_back(adr_cc2mem);
        lat_sel++;
        lat = lat_sel % 3;
      end else begin
        lat--;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_ack"},   {31'd0, ack_cc2cpu}, 32'd0);
    check({nm, "_dat"},   dat_cc2cpu, 32'd0);
    check({nm, "_mreq"},  {31'd0, req_cc2mem}, 32'd0);
    check({nm, "_madr"},  adr_cc2mem, 32'd0);
    check({nm, "_mshr"},  dat_mem2mshr, 32'd0);
    check({nm, "_wcnt"},  {30'd0, word_mem2mshr}, 32'd0);
    check({nm, "_cdat"},  dat_cc2mshr, 32'd0);
  endtask

  // One CPU transaction; caller is at a negedge with the cache idle.
  task automatic cpu_op(input string nm, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp,
                        input logic miss, input int hold);
    int          log0;
    int          cyc;
    int          extra;
    bit          got;
    logic [31:0] base;
    log0 = mem_log.size();
    base = {a[31:4], 4'h0};
    sb_q.push_back(exp);
    req_cpu2cc  = 1'b1;
    adr_cpu2cc  = a;
    dat_cpu2cc  = d;
    rdwr_cpu2cc = wr;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ack_cc2cpu) begin
        got = 1'b1;
        check({nm, "_data"}, dat_cc2cpu, sb_q.pop_front());
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no ack in %0d cycles, expected ack", nm, cyc);
      sb_q.delete();
    end
    if (miss) begin
      check({nm, "_memreqs"}, mem_log.size() - log0, 32'd4);
      for (int i = 0; i < 4; i++) begin
        if (log0 + i < mem_log.size())
          check($sformatf("%s_madr%0d", nm, i), mem_log[log0 + i], base + 32'(4 * i));
      end
      check({nm, "_mshr"}, dat_mem2mshr, mem_word(base + 32'h0000000C));
      check({nm, "_wcnt"}, {30'd0, word_mem2mshr}, 32'd0);
    end else begin
      check({nm, "_latency"}, cyc, 32'd2);
      check({nm, "_memreqs"}, mem_log.size() - log0, 32'd0);
    end
    check({nm, "_cdat"}, dat_cc2mshr, d);
    @(negedge clk);
    check({nm, "_ackpulse"}, {31'd0, ack_cc2cpu}, 32'd0);
    extra = 0;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      if (ack_cc2cpu) extra++;
    end
    check({nm, "_extra_acks"}, extra, 32'd0);
    req_cpu2cc = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int          log0;
    int          cyc;
    logic [31:0] a;

    vecs[0]  = '{1'b0, 32'h00CC3B40, 32'h00000000, 32'h754CD4A5, 1'b1};
    vecs[1]  = '{1'b1, 32'h00CC3B40, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{1'b0, 32'h00CC3B40, 32'h00000001, 32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{1'b0, 32'h00CC3B44, 32'h00000002, mem_word(32'h00CC3B44), 1'b0};
    vecs[4]  = '{1'b0, 32'h00CC334C, 32'h00000003, mem_word(32'h00CC334C), 1'b1};
    vecs[5]  = '{1'b1, 32'h00CC2348, 32'h12345678, 32'h12345678, 1'b1};
    vecs[6]  = '{1'b0, 32'h00CC2348, 32'h00000004, 32'h12345678, 1'b0};
    vecs[7]  = '{1'b0, 32'h00CC2344, 32'h00000005, mem_word(32'h00CC2344), 1'b0};
    vecs[8]  = '{1'b0, 32'h00CC0340, 32'h00000006, mem_word(32'h00CC0340), 1'b1};
    vecs[9]  = '{1'b0, 32'h00CC3B40, 32'h00000007, 32'hFFFFFFFF, 1'b0};
    vecs[10] = '{1'b0, 32'h00CE0340, 32'h00000008, mem_word(32'h00CE0340), 1'b1};
`ifdef CACHE_LRU_EN
    vecs[11] = '{1'b0, 32'h00CC3B44, 32'h00000009, mem_word(32'h00CC3B44), 1'b0};
    vecs[12] = '{1'b0, 32'h00CC3340, 32'h0000000A, mem_word(32'h00CC3340), 1'b1};
`else
    vecs[11] = '{1'b0, 32'h00CC3344, 32'h00000009, mem_word(32'h00CC3344), 1'b0};
    vecs[12] = '{1'b0, 32'h00CC3B40, 32'h0000000A, 32'h754CD4A5, 1'b1};
`endif

    rst         = 1'b0;
    req_cpu2cc  = 1'b0;
    adr_cpu2cc  = 32'h0;
    dat_cpu2cc  = 32'h0;
    rdwr_cpu2cc = 1'b0;
    dat_mem2cc  = 32'h0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cpu_op($sformatf("vec%0d", i), vecs[i].wr, vecs[i].adr, vecs[i].wdat,
             vecs[i].exp, vecs[i].miss, 0);
    end

    // Stray memory ack while idle must leave the cache untouched.
    stray_req++;
    repeat (3) @(negedge clk);
    cpu_op("stray", 1'b0, 32'h00CE0340, 32'h0000000B, mem_word(32'h00CE0340), 1'b0, 0);

    // Request held well past its ack is serviced once.
    cpu_op("hold", 1'b0, 32'h00CE0344, 32'h0000000C, mem_word(32'h00CE0344), 1'b0, 10);

    // Reset after the second refill word of a miss.
    a    = 32'h00C00080;
    log0 = mem_log.size();
    req_cpu2cc  = 1'b1;
    adr_cpu2cc  = a;
    dat_cpu2cc  = 32'hCAFE0001;
    rdwr_cpu2cc = 1'b0;
    cyc = 0;
    while (mem_log.size() < log0 + 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_words", mem_log.size() - log0, 32'd2);
    @(negedge clk);
    check("midrst_wcnt", {30'd0, word_mem2mshr}, 32'd2);
    check("midrst_mreq", {31'd0, req_cc2mem}, 32'd1);
    check("midrst_mshr", dat_mem2mshr, mem_word(32'h00C00084));
    #2;
    rst        = 1'b0;
    req_cpu2cc = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cpu_op("rerd", 1'b0, a, 32'h0000000D, mem_word(a), 1'b1, 0);
    cpu_op("rerd_hit", 1'b0, a + 32'h4, 32'h0000000E, mem_word(a + 32'h4), 1'b0, 0);
    cpu_op("postrst", 1'b0, 32'h00CC3B40, 32'h0000000F, 32'h754CD4A5, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
